// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   state_e    : controller states (idle, tag lookup, line refill)
//   tag_width  : tag bits left after the index, offset and byte fields are removed
package icache_dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  // Byte-within-word bits; the cache only ever moves whole 32-bit words.
  localparam int WORD_BYTES_W = 2;

  function automatic int tag_width(input int addr_w, input int lines, input int wpl);
    return addr_w - $clog2(lines) - $clog2(wpl) - WORD_BYTES_W;
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Data storage for the instruction cache: DEPTH x 32-bit words.
//   clk    : write clock
//   we     : write enable for one refill beat
//   waddr  : {line index, word offset} being refilled
//   wdata  : refill word
//   raddr  : {line index, word offset} of the current lookup
//   rdata  : asynchronous read data for raddr
module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache between the core fetch path and
// main memory. Hits are answered from local storage in the lookup cycle; a
// miss refills the whole line word by word (word 0 first) and then re-runs the
// lookup, which hits. flush invalidates every line (FENCE.I).
//   clk, reset            : clock, synchronous active-high reset
//   icache_addr/req       : fetch request, address held until icache_ready
//   icache_rdata/ready    : one-cycle response pulse with the instruction word
//   flush                 : single-cycle invalidate-all pulse
//   mem_addr/req          : refill beat request, held until mem_valid
//   mem_rdata/valid       : refill beat data / beat completion
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           icache_addr,
  input  logic                  icache_req,
  output logic [31:0]           icache_rdata,
  output logic                  icache_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_valid
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = tag_width(ADDR_WIDTH, LINES, WORDS_PER_LINE);
  localparam int RAM_AW = IDX_W + OFF_W;

  state_e state, state_nxt;

  // Word address of the request being served, split into its fields.
  logic [ADDR_WIDTH-1:WORD_BYTES_W] addr_q;
  logic [OFF_W-1:0]                 off_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [TAG_W-1:0]                 tag_q;

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid;
  logic [OFF_W-1:0] cnt;
  logic             flush_pending;

  logic        hit;
  logic        beat_done;
  logic        last_beat;
  logic        lookup_hit;
  logic        clear_all;
  logic [31:0] ram_rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{icache_addr[31:ADDR_WIDTH], icache_addr[WORD_BYTES_W-1:0]};

  assign off_q = addr_q[WORD_BYTES_W+OFF_W-1 -: OFF_W];
  assign idx_q = addr_q[WORD_BYTES_W+OFF_W+IDX_W-1 -: IDX_W];
  assign tag_q = addr_q[ADDR_WIDTH-1 -: TAG_W];

  assign hit        = valid[idx_q] && (tag_mem[idx_q] == tag_q);
  assign lookup_hit = (state == ST_LOOKUP) && hit;
  assign beat_done  = (state == ST_REFILL) && mem_valid;
  assign last_beat  = beat_done && (cnt == OFF_W'(WORDS_PER_LINE - 1));

  // A flush seen outside a refill clears at once; one seen during a refill is
  // deferred until the refilled request has been answered (LOOKUP -> IDLE).
  assign clear_all = (flush && (state != ST_REFILL)) || (lookup_hit && flush_pending);

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      valid         <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_LOOKUP) begin
        cnt <= '0;
      end else if (beat_done) begin
        cnt <= cnt + OFF_W'(1);
      end

      if (flush && (state == ST_REFILL)) begin
        flush_pending <= 1'b1;
      end else if (lookup_hit) begin
        flush_pending <= 1'b0;
      end

      if (clear_all) begin
        valid <= '0;
      end else if (last_beat) begin
        valid[idx_q] <= 1'b1;
      end
    end
  end

  // ---- request address and tag storage ----
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && icache_req) begin
      addr_q <= icache_addr[ADDR_WIDTH-1:WORD_BYTES_W];
    end
    if (last_beat) begin
      tag_mem[idx_q] <= tag_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (icache_req) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = hit ? ST_IDLE : ST_REFILL;
      ST_REFILL: if (last_beat) state_nxt = ST_LOOKUP;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---- responses ----
  assign icache_ready = lookup_hit;
  assign icache_rdata = lookup_hit ? ram_rdata : '0;
  assign mem_req      = (state == ST_REFILL);
  assign mem_addr     = mem_req ? {tag_q, idx_q, cnt, {WORD_BYTES_W{1'b0}}} : '0;

  icache_data_ram #(
    .DEPTH (LINES * WORDS_PER_LINE),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk   (clk),
    .we    (beat_done),
    .waddr ({idx_q, cnt}),
    .wdata (mem_rdata),
    .raddr ({idx_q, off_q}),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (64 lines x 4 words, 24-bit addresses).
// The memory model answers every refill beat with addr ^ 32'hA5A5_0000 after a
// programmable number of wait cycles. A line-level model (valid/tag per index)
// predicts hit or miss, beat addresses, latency and data for every fetch.
module tb_icache_dm;

  logic        clk;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_rdata;
  logic        icache_ready;
  logic        flush;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  int n_vec;
  int n_bad;
  int mem_wait;
  int wait_cnt;

  bit mvalid [64];
  int mtag   [64];

  localparam int MAX_CYC = 200;

  icache_dm dut (
    .clk          (clk),
    .reset        (reset),
    .icache_addr  (icache_addr),
    .icache_req   (icache_req),
    .icache_rdata (icache_rdata),
    .icache_ready (icache_ready),
    .flush        (flush),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: each beat lasts mem_wait+1 cycles.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= mem_wait) begin
          mem_valid = 1'b1;
          mem_rdata = {8'h00, mem_addr} ^ 32'hA5A5_0000;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'h00, a[23:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  // One fetch. flush_cyc / rst_cyc (>0) pulse flush or reset in that cycle,
  // counting cycle 1 as the one right after the request-sampling edge.
  task automatic fetch(input logic [31:0] a, input int flush_cyc, input int rst_cyc,
                       output logic [31:0] rd, output int lat, output int beats,
                       output logic [23:0] first_ba, output logic [23:0] last_ba);
    int idx;
    int tag;
    bit hit;
    bit done;
    idx = int'((a >> 4) % 64);
    tag = int'((a & 32'h00FF_FFFF) >> 10);
    hit = mvalid[idx] && (mtag[idx] == tag);
    rd = '0; lat = 0; beats = 0; first_ba = '0; last_ba = '0; done = 1'b0;
    @(negedge clk);
    icache_addr = a;
    icache_req  = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= MAX_CYC && !done; cyc++) begin
      @(negedge clk);
      flush = 1'b0;
      if (mem_req) begin
        chk("mem_addr", {8'h00, mem_addr}, (a & 32'h00FF_FFF0) + 32'(4 * beats));
        if (beats == 0) first_ba = mem_addr;
        last_ba = mem_addr;
        if (mem_valid) beats++;
      end
      if (cyc == flush_cyc) flush = 1'b1;
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        icache_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mem_req_after_reset", {31'd0, mem_req}, 32'd0);
        chk("ready_after_reset", {31'd0, icache_ready}, 32'd0);
        clear_model();
        lat  = -1;
        done = 1'b1;
      end else if (icache_ready) begin
        rd  = icache_rdata;
        lat = cyc;
        chk("rdata", icache_rdata, mem_word(a));
        icache_req = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: no ready for addr %h within %0d cycles", a, MAX_CYC);
      icache_req = 1'b0;
    end else if (lat > 0) begin
      @(negedge clk);
      flush = 1'b0;
      chk("mem_req_idle", {31'd0, mem_req}, 32'd0);
      chk("ready_idle", {31'd0, icache_ready}, 32'd0);
      chk("beats", 32'(beats), hit ? 32'd0 : 32'(4));
      chk("latency", 32'(lat), hit ? 32'd1 : 32'(2 + 4 * (mem_wait + 1)));
      if (!hit) begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = tag;
      end
      if (flush_cyc > 0) clear_model();
    end
  endtask

  logic [31:0] rd;
  int          lat;
  int          beats;
  logic [23:0] fba;
  logic [23:0] lba;

  initial begin
    n_vec = 0;
    n_bad = 0;
    mem_wait = 0;
    reset = 1'b1;
    icache_addr = '0;
    icache_req = 1'b0;
    flush = 1'b0;
    clear_model();
    for (int i = 0; i < 64; i++) mtag[i] = 0;

    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, icache_ready}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_rdata", icache_rdata, 32'd0);
    chk("reset_mem_addr", {8'h00, mem_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Cold miss on line 0
    fetch(32'h0000_0000, -1, -1, rd, lat, beats, fba, lba);
    chk("t1_rdata", rd, 32'hA5A5_0000);
    chk("t1_first_beat", {8'h00, fba}, 32'h0);
    chk("t1_last_beat", {8'h00, lba}, 32'hC);
    chk("t1_latency", 32'(lat), 32'd6);

    // Hit in the same line
    fetch(32'h0000_0008, -1, -1, rd, lat, beats, fba, lba);
    chk("t2_rdata", rd, 32'hA5A5_0008);
    chk("t2_latency", 32'(lat), 32'd1);
    chk("t2_beats", 32'(beats), 32'd0);

    // Conflict on index 0 with a new tag, then the old line misses again
    fetch(32'h0000_0400, -1, -1, rd, lat, beats, fba, lba);
    chk("t3_first_beat", {8'h00, fba}, 32'h400);
    chk("t3_last_beat", {8'h00, lba}, 32'h40C);
    fetch(32'h0000_0000, -1, -1, rd, lat, beats, fba, lba);
    chk("t3_remiss_beats", 32'(beats), 32'd4);

    // Flush during refill: response still delivered, line invalid afterwards
    fetch(32'h0000_0010, 3, -1, rd, lat, beats, fba, lba);
    chk("t4_rdata", rd, 32'hA5A5_0010);
    fetch(32'h0000_0010, -1, -1, rd, lat, beats, fba, lba);
    chk("t4_refill_beats", 32'(beats), 32'd4);

    // Reset during the second refill beat
    fetch(32'h0000_0000, -1, 3, rd, lat, beats, fba, lba);
    repeat (2) @(negedge clk);
    fetch(32'h0000_0000, -1, -1, rd, lat, beats, fba, lba);
    chk("t5_miss_beats", 32'(beats), 32'd4);
    fetch(32'h0000_0010, -1, -1, rd, lat, beats, fba, lba);
    chk("t5_line1_cleared", 32'(beats), 32'd4);

    // Slow memory: 3 wait cycles per beat
    mem_wait = 3;
    fetch(32'h0000_003C, -1, -1, rd, lat, beats, fba, lba);
    chk("t6_latency", 32'(lat), 32'd18);
    chk("t6_rdata", rd, 32'hA5A5_003C);
    mem_wait = 0;

    // Flush coinciding with a lookup hit: response delivered, then line gone
    fetch(32'h0000_003C, 1, -1, rd, lat, beats, fba, lba);
    chk("t7_hit_rdata", rd, 32'hA5A5_003C);
    fetch(32'h0000_003C, -1, -1, rd, lat, beats, fba, lba);
    chk("t7_after_flush", 32'(beats), 32'd4);

    // Flush while idle
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mvalid[3] = 1'b0;
    fetch(32'h0000_0038, -1, -1, rd, lat, beats, fba, lba);
    chk("t8_idle_flush", 32'(beats), 32'd4);
    chk("t8_rdata", rd, 32'hA5A5_0038);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
